// File: rtl/instruction_decode_stage_if.sv
// Handshake/bus bundle for the RV32I decode stage.
//   Upstream side : in_valid, in_ready, in_instruction, in_pc, flush
//   Downstream    : out_valid, out_ready, out_pc and the decoded fields
//                   (rs1, rs2, register_write_select, write_enable,
//                   immediate, op_class, funct3, funct7_5, illegal)
// modport slave  : the decode stage itself
// modport master : the environment driving the stage (fetch + consumer)
interface instruction_decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instruction;
  logic [XLEN-1:0] in_pc;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      register_write_select;
  logic            write_enable;
  logic [XLEN-1:0] immediate;
  logic [3:0]      op_class;
  logic [2:0]      funct3;
  logic            funct7_5;
  logic            illegal;

  modport slave (
    input  in_valid, in_instruction, in_pc, flush, out_ready,
    output in_ready, out_valid, out_pc, rs1, rs2, register_write_select,
           write_enable, immediate, op_class, funct3, funct7_5, illegal
  );

  modport master (
    output in_valid, in_instruction, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_pc, rs1, rs2, register_write_select,
           write_enable, immediate, op_class, funct3, funct7_5, illegal
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// RV32I decode stage placed in front of the register file.
// Decodes in_instruction combinationally and captures the result plus the
// PC into a single-entry pipeline register with valid/ready on both sides.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, clears every register
//   bus   : instruction_decode_stage_if.slave (handshake, flush, fields)
module instruction_decode_stage #(
  parameter int XLEN = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  instruction_decode_stage_if.slave   bus
);

  typedef enum logic [3:0] {
    CLS_LUI     = 4'd0,
    CLS_AUIPC   = 4'd1,
    CLS_JAL     = 4'd2,
    CLS_JALR    = 4'd3,
    CLS_BRANCH  = 4'd4,
    CLS_LOAD    = 4'd5,
    CLS_STORE   = 4'd6,
    CLS_OP_IMM  = 4'd7,
    CLS_OP      = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd15
  } op_class_e;

  logic [31:0] instr;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  op_class_e   dec_class;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_we;
  logic [31:0] dec_imm;
  logic        dec_f7_5;

  assign instr = bus.in_instruction;
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Class selection folds in every legality rule, so anything that does not
  // land on a real class stays CLS_ILLEGAL and gets all-zero fields below.
  always_comb begin
    dec_class = CLS_ILLEGAL;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:2])
        5'b01101: dec_class = CLS_LUI;
        5'b00101: dec_class = CLS_AUIPC;
        5'b11011: dec_class = CLS_JAL;
        5'b11001: if (f3 == 3'd0) dec_class = CLS_JALR;
        5'b11000: if (f3 != 3'd2 && f3 != 3'd3) dec_class = CLS_BRANCH;
        5'b00000: if (f3 != 3'd3 && f3 < 3'd6) dec_class = CLS_LOAD;
        5'b01000: if (f3 < 3'd3) dec_class = CLS_STORE;
        5'b00100: begin
          // Shift-immediates carry funct7 in the immediate field.
          if (f3 == 3'd1) begin
            if (f7 == 7'h00) dec_class = CLS_OP_IMM;
          end else if (f3 == 3'd5) begin
            if (f7 == 7'h00 || f7 == 7'h20) dec_class = CLS_OP_IMM;
          end else begin
            dec_class = CLS_OP_IMM;
          end
        end
        5'b01100: begin
          if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))
            dec_class = CLS_OP;
        end
        5'b00011: dec_class = CLS_FENCE;
        5'b11100: dec_class = CLS_SYSTEM;
        default:  dec_class = CLS_ILLEGAL;
      endcase
    end
  end

  always_comb begin
    dec_rs1  = 5'd0;
    dec_rs2  = 5'd0;
    dec_rd   = 5'd0;
    dec_imm  = 32'd0;
    dec_f7_5 = 1'b0;
    case (dec_class)
      CLS_LUI, CLS_AUIPC: begin
        dec_rd  = instr[11:7];
        dec_imm = imm_u;
      end
      CLS_JAL: begin
        dec_rd  = instr[11:7];
        dec_imm = imm_j;
      end
      CLS_JALR, CLS_LOAD: begin
        dec_rs1 = instr[19:15];
        dec_rd  = instr[11:7];
        dec_imm = imm_i;
      end
      CLS_OP_IMM: begin
        dec_rs1  = instr[19:15];
        dec_rd   = instr[11:7];
        dec_imm  = imm_i;
        dec_f7_5 = (f3 == 3'd1 || f3 == 3'd5) ? instr[30] : 1'b0;
      end
      CLS_BRANCH: begin
        dec_rs1 = instr[19:15];
        dec_rs2 = instr[24:20];
        dec_imm = imm_b;
      end
      CLS_STORE: begin
        dec_rs1 = instr[19:15];
        dec_rs2 = instr[24:20];
        dec_imm = imm_s;
      end
      CLS_OP: begin
        dec_rs1  = instr[19:15];
        dec_rs2  = instr[24:20];
        dec_rd   = instr[11:7];
        dec_f7_5 = instr[30];
      end
      default: ;
    endcase
  end

  // dec_rd is already zero for classes that never write, so a non-zero rd
  // is exactly the write condition (x0 writes fall out naturally).
  assign dec_we = (dec_rd != 5'd0);

  logic            valid_reg;
  logic [XLEN-1:0] pc_reg;
  logic [4:0]      rs1_reg, rs2_reg, rd_reg;
  logic            we_reg;
  logic [XLEN-1:0] imm_reg;
  logic [3:0]      class_reg;
  logic [2:0]      f3_reg;
  logic            f7_5_reg;
  logic            illegal_reg;
  logic            capture;

  assign bus.in_ready = !valid_reg || bus.out_ready;
  assign capture      = bus.in_valid && bus.in_ready && !bus.flush;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_reg   <= 1'b0;
      pc_reg      <= '0;
      rs1_reg     <= 5'd0;
      rs2_reg     <= 5'd0;
      rd_reg      <= 5'd0;
      we_reg      <= 1'b0;
      imm_reg     <= '0;
      class_reg   <= 4'd0;
      f3_reg      <= 3'd0;
      f7_5_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      if (bus.flush) begin
        valid_reg <= 1'b0;
      end else if (capture) begin
        valid_reg <= 1'b1;
      end else if (bus.out_ready) begin
        valid_reg <= 1'b0;
      end

      // Data fields only move on capture; after a flush or drain they keep
      // stale values, which is harmless because out_valid is low.
      if (capture) begin
        pc_reg      <= bus.in_pc;
        rs1_reg     <= dec_rs1;
        rs2_reg     <= dec_rs2;
        rd_reg      <= dec_rd;
        we_reg      <= dec_we;
        imm_reg     <= dec_imm;
        class_reg   <= dec_class;
        f3_reg      <= f3;
        f7_5_reg    <= dec_f7_5;
        illegal_reg <= (dec_class == CLS_ILLEGAL);
      end
    end
  end

  assign bus.out_valid             = valid_reg;
  assign bus.out_pc                = pc_reg;
  assign bus.rs1                   = rs1_reg;
  assign bus.rs2                   = rs2_reg;
  assign bus.register_write_select = rd_reg;
  assign bus.write_enable          = we_reg;
  assign bus.immediate             = imm_reg;
  assign bus.op_class              = class_reg;
  assign bus.funct3                = f3_reg;
  assign bus.funct7_5              = f7_5_reg;
  assign bus.illegal               = illegal_reg;

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: directed steps from the
// test plan followed by a randomized run against a behavioural model.
module tb_instruction_decode_stage;

  logic clock = 1'b0;
  logic reset = 1'b0;

  instruction_decode_stage_if #(.XLEN(32)) bus ();

  instruction_decode_stage #(.XLEN(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  cls;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] imm;
    logic [2:0]  f3;
    logic        f75;
    logic        ill;
  } exp_t;

  exp_t        m_entry;
  logic [31:0] m_pc;
  bit          m_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference decode: written straight from the ISA rules with integer
  // arithmetic for the immediates.
  function automatic exp_t model(input logic [31:0] w);
    exp_t e;
    int opc, f3, f7, cls, imm;
    bit writes;
    opc = int'(w[6:0]);
    f3  = int'(w[14:12]);
    f7  = int'(w[31:25]);
    case (opc)
      'h37:    cls = 0;
      'h17:    cls = 1;
      'h6F:    cls = 2;
      'h67:    cls = (f3 == 0) ? 3 : 15;
      'h63:    cls = (f3 == 2 || f3 == 3) ? 15 : 4;
      'h03:    cls = (f3 == 3 || f3 >= 6) ? 15 : 5;
      'h23:    cls = (f3 >= 3) ? 15 : 6;
      'h13:    cls = ((f3 == 1 && f7 != 0) || (f3 == 5 && f7 != 0 && f7 != 'h20)) ? 15 : 7;
      'h33:    cls = (f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5))) ? 8 : 15;
      'h0F:    cls = 9;
      'h73:    cls = 10;
      default: cls = 15;
    endcase
    case (cls)
      0, 1:    imm = int'(w & 32'hFFFFF000);
      2:       imm = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
      3, 5, 7: imm = (w[31] ? -2048 : 0) + int'(w[30:20]);
      4:       imm = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
      6:       imm = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]);
      default: imm = 0;
    endcase
    writes = cls inside {0, 1, 2, 3, 5, 7, 8};
    e.cls = 4'(cls);
    e.ill = (cls == 15);
    e.f3  = w[14:12];
    e.imm = 32'(imm);
    e.rs1 = (cls inside {3, 4, 5, 6, 7, 8}) ? w[19:15] : 5'd0;
    e.rs2 = (cls inside {4, 6, 8}) ? w[24:20] : 5'd0;
    e.rd  = writes ? w[11:7] : 5'd0;
    e.we  = writes && (w[11:7] != 5'd0);
    e.f75 = (cls == 8 || (cls == 7 && (f3 == 1 || f3 == 5))) ? w[30] : 1'b0;
    return e;
  endfunction

  task automatic compare_outputs();
    check("out_valid", 32'(bus.out_valid), 32'(m_valid));
    if (m_valid) begin
      check("out_pc",       bus.out_pc, m_pc);
      check("op_class",     32'(bus.op_class), 32'(m_entry.cls));
      check("rs1",          32'(bus.rs1), 32'(m_entry.rs1));
      check("rs2",          32'(bus.rs2), 32'(m_entry.rs2));
      check("rd",           32'(bus.register_write_select), 32'(m_entry.rd));
      check("write_enable", 32'(bus.write_enable), 32'(m_entry.we));
      check("immediate",    bus.immediate, m_entry.imm);
      check("funct3",       32'(bus.funct3), 32'(m_entry.f3));
      check("funct7_5",     32'(bus.funct7_5), 32'(m_entry.f75));
      check("illegal",      32'(bus.illegal), 32'(m_entry.ill));
    end
  endtask

  // One clock cycle: drive inputs, check in_ready, advance, update the
  // model and compare every output.
  task automatic tick(input bit iv, input logic [31:0] instr, input logic [31:0] pc,
                      input bit ordy, input bit fl);
    bit cap;
    bus.in_valid       = iv;
    bus.in_instruction = instr;
    bus.in_pc          = pc;
    bus.out_ready      = ordy;
    bus.flush          = fl;
    #1;
    check("in_ready", 32'(bus.in_ready), 32'(!m_valid || ordy));
    cap = iv && (!m_valid || ordy) && !fl;
    @(posedge clock);
    #1;
    if (fl) begin
      m_valid = 1'b0;
    end else if (cap) begin
      m_valid = 1'b1;
      m_entry = model(instr);
      m_pc    = pc;
    end else if (ordy) begin
      m_valid = 1'b0;
    end
    $display("t=%0t iv=%0d instr=%08h pc=%08h ordy=%0d flush=%0d cap=%0d out_valid=%0d class=%0d",
             $time, iv, instr, pc, ordy, fl, cap, bus.out_valid, bus.op_class);
    compare_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [11];
    logic [31:0] w;
    int          sel;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    w   = $urandom;
    sel = $urandom_range(0, 12);
    if (sel < 11) w[6:0] = ops[sel];
    else if (sel == 12) w[1:0] = 2'($urandom_range(0, 2));
    case ($urandom_range(0, 2))
      0:       w[31:25] = 7'h00;
      1:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    bus.in_valid       = 1'b0;
    bus.in_instruction = 32'd0;
    bus.in_pc          = 32'd0;
    bus.out_ready      = 1'b0;
    bus.flush          = 1'b0;

    // Reset state
    #7;
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_in_ready",  32'(bus.in_ready), 32'd1);
    check("reset_immediate", bus.immediate, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // addi x1,x0,5
    tick(1'b1, 32'h00500093, 32'h00000100, 1'b1, 1'b0);
    check("addi_class", 32'(bus.op_class), 32'd7);
    check("addi_rd",    32'(bus.register_write_select), 32'd1);
    check("addi_imm",   bus.immediate, 32'h00000005);
    check("addi_we",    32'(bus.write_enable), 32'd1);

    // sw x2,-4(x1)
    tick(1'b1, 32'hFE20AE23, 32'h00000104, 1'b1, 1'b0);
    check("sw_class", 32'(bus.op_class), 32'd6);
    check("sw_rs1",   32'(bus.rs1), 32'd1);
    check("sw_rs2",   32'(bus.rs2), 32'd2);
    check("sw_imm",   bus.immediate, 32'hFFFFFFFC);
    check("sw_we",    32'(bus.write_enable), 32'd0);

    // lui x5,0x12345 then nop back-to-back
    tick(1'b1, 32'h123452B7, 32'h00000108, 1'b1, 1'b0);
    check("lui_imm",   bus.immediate, 32'h12345000);
    check("lui_we",    32'(bus.write_enable), 32'd1);
    check("lui_valid", 32'(bus.out_valid), 32'd1);
    tick(1'b1, 32'h00000013, 32'h0000010C, 1'b1, 1'b0);
    check("nop_we",    32'(bus.write_enable), 32'd0);
    check("nop_valid", 32'(bus.out_valid), 32'd1);

    // Backpressure: drain, capture one, hold the second upstream, then flush
    tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick(1'b1, 32'h00208133, 32'h00000200, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 32'h40208133, 32'h00000204, 1'b0, 1'b0);
      check("stall_in_ready", 32'(bus.in_ready), 32'd0);
      check("stall_pc",       bus.out_pc, 32'h00000200);
    end
    tick(1'b1, 32'h40208133, 32'h00000204, 1'b0, 1'b1);
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    tick(1'b1, 32'h40208133, 32'h00000204, 1'b1, 1'b0);

    // Illegal encodings
    tick(1'b1, 32'hFFFFFFFF, 32'h00000300, 1'b1, 1'b0);
    check("ill1_flag",  32'(bus.illegal), 32'd1);
    check("ill1_class", 32'(bus.op_class), 32'd15);
    check("ill1_valid", 32'(bus.out_valid), 32'd1);
    tick(1'b1, 32'h0000A063, 32'h00000304, 1'b1, 1'b0);
    check("ill2_flag",  32'(bus.illegal), 32'd1);
    check("ill2_class", 32'(bus.op_class), 32'd15);
    check("ill2_we",    32'(bus.write_enable), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 3) != 0, rand_instr(), $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 11) == 0);
    end

    // Reset asserted mid-cycle while an entry is stalled
    tick(1'b1, 32'h123452B7, 32'h00000400, 1'b0, 1'b0);
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    m_valid = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_immediate", bus.immediate, 32'd0);
    check("rst_we",        32'(bus.write_enable), 32'd0);
    check("rst_rd",        32'(bus.register_write_select), 32'd0);
    check("rst_pc",        bus.out_pc, 32'd0);
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    @(negedge clock);
    reset = 1'b1;
    tick(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_decode_stage.md
Name: instruction_decode_stage

Overview:
RV32I decode stage that sits directly upstream of the register file.
- Takes a fetched 32-bit instruction and its PC.
- Produces the register-file read selects (rs1, rs2), write select and write enable, plus the sign-extended immediate and an operation class.
- Results are held in a single-entry pipeline register with a valid/ready handshake on both sides and a flush input for control-flow redirects.

Parameters:
XLEN, 32, datapath width for instruction, PC and immediate (only 32 supported)

Ports:
clock  input  1  single clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low; clears all state immediately when low
in_valid  input  1  upstream holds a valid instruction
in_ready  output  1  stage can accept an instruction this cycle
in_instruction  input  32  raw instruction word
in_pc  input  32  PC of in_instruction
flush  input  1  drop the held entry and block capture this cycle
out_valid  output  1  decoded entry present
out_ready  input  1  downstream consumes the entry this cycle
out_pc  output  32  PC of the held entry
rs1  output  5  register-file read select 1
rs2  output  5  register-file read select 2
register_write_select  output  5  destination register (rd)
write_enable  output  1  entry writes rd
immediate  output  32  sign-extended immediate
op_class  output  4  operation class: 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OP_IMM, 8 OP, 9 FENCE, 10 SYSTEM, 15 ILLEGAL
funct3  output  3  instruction bits [14:12]
funct7_5  output  1  instruction bit 30, valid for OP and for OP_IMM shifts; 0 otherwise
illegal  output  1  entry failed decode

Behaviour:
- Reset (reset low, asynchronous): every output register goes to 0, including out_valid. After reset, in_ready = 1.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Capture condition: in_valid && in_ready && !flush.
  - Latency: one cycle from capture to out_valid.
- out_valid update on the next edge:
  - flush → 0.
  - else capture → 1.
  - else out_ready → 0.
  - else unchanged.
- Simultaneous consume and capture: the new entry replaces the old one and out_valid stays 1, giving back-to-back throughput of one instruction per cycle.
- Stall: while out_valid && !out_ready, all outputs hold stable.
- flush:
  - Has priority over capture; in_valid is ignored that cycle.
  - Data fields may retain stale values once out_valid = 0.
- Output fields for invalid entries are don't-care, except out_valid.
- Decode is combinational from in_instruction and registered on capture.
- Immediates (sign bit is instr[31]):
  - I: instr[31:20].
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U: {instr[31:12], 12'b0}.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - FENCE, SYSTEM, OP: immediate = 0.
- rs1 = instr[19:15] for JALR, BRANCH, LOAD, STORE, OP_IMM, OP; otherwise 0.
- rs2 = instr[24:20] for BRANCH, STORE, OP; otherwise 0.
- register_write_select = instr[11:7] for classes that write rd; otherwise 0.
- write_enable = 1 only when both hold:
  - class is LUI, AUIPC, JAL, JALR, LOAD, OP_IMM or OP;
  - rd != 0 (x0 writes are suppressed).
- Illegal when any of:
  - instr[1:0] != 2'b11;
  - unknown opcode;
  - JALR funct3 != 0;
  - BRANCH funct3 is 2 or 3;
  - LOAD funct3 is 3, 6 or 7;
  - STORE funct3 >= 3;
  - OP funct7 is not 0x00/0x20, or is 0x20 with funct3 not 0 or 5;
  - OP_IMM funct3=1 with funct7 != 0x00;
  - OP_IMM funct3=5 with funct7 not 0x00/0x20.
- Illegal entries:
  - Still flow through with out_valid = 1.
  - illegal = 1, op_class = 15.
  - write_enable = 0, rs1 = rs2 = register_write_select = 0, immediate = 0.
- Reset mid-stall: entry discarded, out_valid = 0 immediately; no entry emitted after reset releases.

Test Plan:
- addi x1,x0,5 (0x00500093) with out_ready=1 → next cycle:
  - out_valid=1, op_class=7, rd=1, rs1=0, rs2=0, immediate=0x00000005, write_enable=1.
- sw x2,-4(x1) (0xFE20AE23) → op_class=6, rs1=1, rs2=2, immediate=0xFFFFFFFC, write_enable=0, register_write_select=0.
- lui x5,0x12345 (0x123452B7) then nop (0x00000013) back-to-back:
  - First entry: immediate=0x12345000, rs1=0, write_enable=1.
  - Second entry: write_enable=0 because rd=x0.
  - out_valid stays high both cycles.
- Backpressure and flush:
  - Hold out_ready=0 and present two instructions → second is held upstream with in_ready=0; outputs stable for 3 cycles.
  - Assert flush → out_valid=0 next cycle; no capture during the flush cycle.
- 0xFFFFFFFF and 0x0000A063 (branch funct3=2) → illegal=1, op_class=15, write_enable=0, out_valid=1.
- Assert reset low mid-cycle while an entry is stalled → out_valid=0 and all outputs 0 immediately, without waiting for a clock edge; in_ready=1 after release.
